// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: sequential significand multiplier for the FPU arithmetic unit.
//
// A 24x24 radix-2 shift-add multiplier retires one multiplier bit per cycle.
// The 48-bit product is then normalized into a 27-bit significand
// {hidden, 23 fraction, G, R, S} with a biased exponent and overflow/underflow
// flags, ready for the shared rounder.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   mul_start        start request, accepted only in IDLE or DONE
//   exp_A, exp_B     effective biased exponents (subnormals arrive as 1)
//   sig_A, sig_B     significands including the hidden bit
//   mul_proNorm_sig  normalized significand [26]=hidden [25:3]=frac [2]=G [1]=R [0]=S
//   mul_proNorm_exp  result biased exponent
//   mul_rdy          one-cycle completion pulse
//   OF_from_proNorm  exponent overflow (exp forced to 8'hFF)
//   UF_from_proNorm  result is subnormal / underflowed
//
// Timing: a start sampled at edge k gives mul_rdy high from edge k+26 to k+27.
// mul_rdy is registered as the FSM leaves DONE, so a start held high is
// re-accepted in DONE and back-to-back operations are 26 cycles apart.
module fpu_mul_seq #(
  parameter int BIAS  = 127,
  parameter int SIG_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mul_start,
  input  logic [7:0]         exp_A,
  input  logic [7:0]         exp_B,
  input  logic [SIG_W-1:0]   sig_A,
  input  logic [SIG_W-1:0]   sig_B,
  output logic [SIG_W+2:0]   mul_proNorm_sig,
  output logic [7:0]         mul_proNorm_exp,
  output logic               mul_rdy,
  output logic               OF_from_proNorm,
  output logic               UF_from_proNorm
);

  localparam int PROD_W = 2 * SIG_W;
  localparam int CNT_W  = $clog2(SIG_W);
  localparam int LZ_W   = $clog2(PROD_W + 1);
  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                    state;
  logic        [CNT_W-1:0]   count;
  logic        [PROD_W-1:0]  acc;
  logic        [PROD_W-1:0]  mcand;
  logic        [SIG_W-1:0]   mplier;
  logic        [7:0]         exp_a;
  logic        [7:0]         exp_b;

  logic signed [9:0]         e;
  logic signed [9:0]         ez;
  logic        [PROD_W-1:0]  q;
  logic        [LZ_W-1:0]    z;
  logic        [PROD_W:0]    rs;
  logic                      lost;
  logic        [SIG_W+2:0]   norm_sig;
  logic        [7:0]         norm_exp;
  logic                      norm_of;
  logic                      norm_uf;

  // Leading-zero count; the highest set bit wins because it is visited last.
  function automatic logic [LZ_W-1:0] lzc(input logic [PROD_W-1:0] v);
    lzc = LZ_W'(PROD_W);
    for (int i = 0; i < PROD_W; i++)
      if (v[i]) lzc = LZ_W'(PROD_W - 1 - i);
  endfunction

  // Right shift returning {shifted value, OR of every bit shifted out}.
  function automatic logic [PROD_W:0] shr_sticky(input logic [PROD_W-1:0] v,
                                                 input logic [9:0]        sh);
    if (sh >= 10'(PROD_W))
      shr_sticky = {{PROD_W{1'b0}}, |v};
    else
      shr_sticky = {v >> sh, |(v & ~({PROD_W{1'b1}} << sh))};
  endfunction

  // Normalization of the finished product held in acc.
  always_comb begin
    e        = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S
               + $signed({9'd0, acc[PROD_W-1]});
    q        = acc[PROD_W-1] ? acc : (acc << 1);
    z        = lzc(q);
    ez       = e - $signed({{(10 - LZ_W){1'b0}}, z});
    rs       = '0;
    lost     = 1'b0;
    norm_exp = '0;
    norm_of  = 1'b0;
    norm_uf  = 1'b0;
    if (acc == '0) begin
      q = '0;
    end else if (ez >= 10'sd1) begin
      q = q << z;
      if (ez >= 10'sd255) begin
        norm_of  = 1'b1;
        norm_exp = 8'hFF;
      end else begin
        norm_exp = ez[7:0];
      end
    end else if (e >= 10'sd1) begin
      // Can only shift part of the way: park the value at the subnormal scale.
      q       = q << $unsigned(e - 10'sd1);
      norm_uf = 1'b1;
    end else begin
      rs      = shr_sticky(q, $unsigned(10'sd1 - e));
      q       = rs[PROD_W:1];
      lost    = rs[0];
      norm_uf = 1'b1;
    end
    norm_sig = {q[PROD_W-1:PROD_W-SIG_W-2], (|q[PROD_W-SIG_W-3:0]) | lost};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      acc             <= '0;
      mcand           <= '0;
      mplier          <= '0;
      exp_a           <= '0;
      exp_b           <= '0;
      mul_proNorm_sig <= '0;
      mul_proNorm_exp <= '0;
      mul_rdy         <= 1'b0;
      OF_from_proNorm <= 1'b0;
      UF_from_proNorm <= 1'b0;
    end else begin
      mul_rdy <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) mul_rdy <= 1'b1;
          if (mul_start) begin
            mcand  <= {{SIG_W{1'b0}}, sig_A};
            mplier <= sig_B;
            exp_a  <= exp_A;
            exp_b  <= exp_B;
            acc    <= '0;
            count  <= '0;
            state  <= MUL;
          end else begin
            state  <= IDLE;
          end
        end
        // Multiplicand shifts left alongside the count, so it is always
        // aligned with the multiplier bit being retired.
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CNT_W'(SIG_W - 1)) state <= NORM;
        end
        NORM: begin
          mul_proNorm_sig <= norm_sig;
          mul_proNorm_exp <= norm_exp;
          OF_from_proNorm <= norm_of;
          UF_from_proNorm <= norm_uf;
          state           <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Self-checking bench for fpu_mul_seq: expected results are computed by an
// independent reference (exact product, MSB position, shift-with-sticky) and
// queued when an operation is started; they are compared when mul_rdy pulses.
module tb_fpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        mul_start;
  logic [7:0]  exp_A, exp_B;
  logic [23:0] sig_A, sig_B;
  logic [26:0] mul_proNorm_sig;
  logic [7:0]  mul_proNorm_exp;
  logic        mul_rdy;
  logic        OF_from_proNorm;
  logic        UF_from_proNorm;

  fpu_mul_seq #(.BIAS(127), .SIG_W(24)) dut (
    .clk             (clk),
    .reset           (reset),
    .mul_start       (mul_start),
    .exp_A           (exp_A),
    .exp_B           (exp_B),
    .sig_A           (sig_A),
    .sig_B           (sig_B),
    .mul_proNorm_sig (mul_proNorm_sig),
    .mul_proNorm_exp (mul_proNorm_exp),
    .mul_rdy         (mul_rdy),
    .OF_from_proNorm (OF_from_proNorm),
    .UF_from_proNorm (UF_from_proNorm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] sig;
    logic [7:0]  exp;
    logic        of;
    logic        uf;
    int          st;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   rdy_seen  = 0;
  int   pushed    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  // Reference: the value is P * 2^(ea+eb-127-46); put the MSB of P at bit 26
  // (or at the exponent-1 scale when subnormal) and fold lost bits into bit 0.
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic [7:0] ea, input logic [7:0] eb,
                                 input int st);
    exp_t        r;
    logic [63:0] p, v;
    int          m, ef, sh;
    r.st = st; r.sig = '0; r.exp = '0; r.of = 1'b0; r.uf = 1'b0;
    p = 64'(a) * 64'(b);
    if (p != 64'd0) begin
      m = 0;
      for (int i = 0; i < 48; i++) if (p[i]) m = i;
      ef = int'(ea) + int'(eb) - 127 + (m - 46);
      sh = m - 26;
      if (ef < 1) begin
        sh   = sh + (1 - ef);
        r.uf = 1'b1;
      end else if (ef >= 255) begin
        r.of  = 1'b1;
        r.exp = 8'hFF;
      end else begin
        r.exp = 8'(ef);
      end
      if (sh <= 0)       v = p << (-sh);
      else if (sh >= 64) v = 64'd1;
      else               v = (p >> sh) | {63'd0, (p & ((64'd1 << sh) - 64'd1)) != 64'd0};
      r.sig = v[26:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mul_rdy === 1'b1) begin
      exp_t e;
      rdy_seen++;
      if (sb.size() == 0) begin
        check("unexpected_rdy", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        last_e = e;
        check("sig",     64'(mul_proNorm_sig), 64'(e.sig));
        check("exp",     64'(mul_proNorm_exp), 64'(e.exp));
        check("of",      64'(OF_from_proNorm), 64'(e.of));
        check("uf",      64'(UF_from_proNorm), 64'(e.uf));
        check("latency", 64'(cyc - e.st),      64'd26);
      end
    end
  end

  task automatic op(input logic [23:0] a, input logic [23:0] b,
                    input logic [7:0] ea, input logic [7:0] eb);
    @(negedge clk);
    sig_A = a; sig_B = b; exp_A = ea; exp_B = eb; mul_start = 1'b1;
    sb.push_back(model(a, b, ea, eb, cyc + 1));
    pushed++;
    @(negedge clk);
    mul_start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 80) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_sig"}, 64'(mul_proNorm_sig), 64'd0);
    check({tag, "_exp"}, 64'(mul_proNorm_exp), 64'd0);
    check({tag, "_rdy"}, 64'(mul_rdy),         64'd0);
    check({tag, "_of"},  64'(OF_from_proNorm), 64'd0);
    check({tag, "_uf"},  64'(UF_from_proNorm), 64'd0);
  endtask

  initial begin
    reset = 1'b1; mul_start = 1'b0;
    sig_A = '0; sig_B = '0; exp_A = '0; exp_B = '0;
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // 1.0 x 1.0 -> 27'h4000000, exp 127
    op(24'h800000, 24'h800000, 8'd127, 8'd127); drain();
    check("one_sig", 64'(mul_proNorm_sig), 64'h4000000);
    // 1.5 x 1.5 = 2.25 -> 27'h4800000, exp 128
    op(24'hC00000, 24'hC00000, 8'd127, 8'd127); drain();
    check("onehalf_sig", 64'(mul_proNorm_sig), 64'h4800000);
    check("onehalf_exp", 64'(mul_proNorm_exp), 64'd128);
    // overflow: E = 273
    op(24'h800000, 24'h800000, 8'd200, 8'd200); drain();
    check("of_exp", 64'(mul_proNorm_exp), 64'hFF);
    // deep underflow: E = -125, everything lands in sticky
    op(24'h800000, 24'h800000, 8'd1, 8'd1); drain();
    check("deep_uf_sig", 64'(mul_proNorm_sig), 64'h0000001);
    // partial underflow: 2^-149 * 2^13 = 2^-136 = 2^13 subnormal ulps -> bit 16
    op(24'h000001, 24'h800000, 8'd1, 8'd140); drain();
    check("part_uf_sig", 64'(mul_proNorm_sig), 64'h0010000);
    check("part_uf_uf",  64'(UF_from_proNorm), 64'd1);
    // zero operand
    op(24'h000000, 24'hABCDEF, 8'd127, 8'd127); drain();
    check("zero_sig", 64'(mul_proNorm_sig), 64'd0);

    // random operands, a mix of normal and subnormal significands
    for (int i = 0; i < 10; i++) begin
      logic [23:0] a, b;
      a = 24'($urandom) | 24'h800000;
      b = 24'($urandom) | 24'h800000;
      if (i % 4 == 3) a = 24'($urandom_range(1, 4095));
      op(a, b, 8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)));
      drain();
    end

    // start pulsed during MUL must not disturb the latched operands
    op(24'hC00000, 24'hA00000, 8'd130, 8'd120);
    repeat (5) @(negedge clk);
    sig_A = 24'h123456; sig_B = 24'hFFFFFF; exp_A = 8'd3; exp_B = 8'd9;
    mul_start = 1'b1;
    repeat (3) @(negedge clk);
    mul_start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("hold_sig", 64'(mul_proNorm_sig), 64'(last_e.sig));
    check("hold_exp", 64'(mul_proNorm_exp), 64'(last_e.exp));

    // start held high for 30 cycles: accepted at k and again in DONE at k+26
    @(negedge clk);
    sig_A = 24'hC00000; sig_B = 24'hC00000; exp_A = 8'd127; exp_B = 8'd127;
    mul_start = 1'b1;
    sb.push_back(model(24'hC00000, 24'hC00000, 8'd127, 8'd127, cyc + 1));
    sb.push_back(model(24'hC00000, 24'hC00000, 8'd127, 8'd127, cyc + 27));
    pushed += 2;
    repeat (30) @(negedge clk);
    mul_start = 1'b0;
    drain();

    // reset during MUL: outputs clear, no completion for the aborted operation
    @(negedge clk);
    sig_A = 24'hFFFFFF; sig_B = 24'hFFFFFF; exp_A = 8'd127; exp_B = 8'd127;
    mul_start = 1'b1;
    @(negedge clk) mul_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero_outputs("midreset");
    @(negedge clk) reset = 1'b0;
    repeat (35) @(negedge clk);
    op(24'hFFFFFF, 24'hFFFFFF, 8'd127, 8'd127); drain();

    repeat (3) @(negedge clk);
    check("rdy_count", 64'(rdy_seen), 64'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
